// File: rtl/t07_spi_tft.sv
// SPI serialiser for CPU stores into the TFT MMIO window; ack_TFT stalls the CPU until the frame ends.
// Optional macro T07_TFT_BURST_EN adds 32-bit two-pixel burst data writes selected by addr_in[3].
module t07_spi_tft #(
  parameter int CLK_DIV   = 2,
  parameter int CMD_BITS  = 8,
  parameter int DATA_BITS = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wi_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] writeData_in,
  output logic        ack_TFT,
  output logic        tft_sclk,
  output logic        tft_mosi,
  output logic        tft_cs_n,
  output logic        tft_dc,
  output logic [2:0]  o_dbg_state
);

`ifdef T07_TFT_BURST_EN
  localparam int MAX_BITS = 32;
`else
  localparam int MAX_BITS = (CMD_BITS > DATA_BITS) ? CMD_BITS : DATA_BITS;
`endif
  localparam int BIT_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] CMD_LAST  = BIT_W'(CMD_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic [30:0]      r_shift;
  logic [BIT_W-1:0] r_last;
  logic [BIT_W-1:0] r_bit;
  logic [DIV_W-1:0] r_div;
  logic             r_phase;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_cs_n;
  logic             r_dc;

  logic             w_sel_dc;
  logic [BIT_W-1:0] w_sel_last;
  logic [31:0]      w_sel_payload;
  logic             w_unused;

  // Payload is left-justified so the MSB always leaves from bit 31.
  always_comb begin
    w_sel_dc      = addr_in[2];
    w_sel_last    = addr_in[2] ? DATA_LAST : CMD_LAST;
    w_sel_payload = addr_in[2] ? (writeData_in << (32 - DATA_BITS))
                               : (writeData_in << (32 - CMD_BITS));
`ifdef T07_TFT_BURST_EN
    if (addr_in[3]) begin
      w_sel_dc      = 1'b1;
      w_sel_last    = BIT_W'(31);
      w_sel_payload = writeData_in;
    end
`endif
  end

  assign w_unused = ^{addr_in[31:3], addr_in[1:0]};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_last  <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_phase <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_dc    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (wi_in) begin
            r_shift <= w_sel_payload[30:0];
            r_mosi  <= w_sel_payload[31];
            r_last  <= w_sel_last;
            r_dc    <= w_sel_dc;
            r_cs_n  <= 1'b0;
            r_sclk  <= 1'b0;
            r_bit   <= '0;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_state <= LOAD;
          end
        end
        LOAD: r_state <= SHIFT;
        SHIFT: begin
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (!r_phase) begin
              r_sclk  <= 1'b1;
              r_phase <= 1'b1;
            end else begin
              r_sclk  <= 1'b0;
              r_phase <= 1'b0;
              if (r_bit == r_last) begin
                r_state <= HOLD;
              end else begin
                // Falling edge: present the next bit for the following rising sample.
                r_bit   <= r_bit + 1'b1;
                r_mosi  <= r_shift[30];
                r_shift <= {r_shift[29:0], 1'b0};
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        HOLD: begin
          if (r_div == DIV_LAST) begin
            r_div   <= '0;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Busy rises combinationally on a request so the CPU never sees a false completion.
  assign ack_TFT     = nrst & ((r_state == IDLE) ? wi_in : (r_state != DONE));
  assign tft_sclk    = r_sclk;
  assign tft_mosi    = r_mosi;
  assign tft_cs_n    = r_cs_n;
  assign tft_dc      = r_dc;
  assign o_dbg_state = r_state;

endmodule
